online_div_digit_sequencer: RTL and testbench
=============================================

Name: online_div_digit_sequencer

Overview:
- Upstream feeder for the CA-register generator of the online divider.
- Accepts signed-digit operand streams x and y over a valid/ready handshake and drives the generator's enable, refresh, x_in, y_in, counter, shift_cnt and accum inputs.
- Pads each division with ONLINE_DELAY zero digits so the generator and RAM always see exactly UNROLLING enabled cycles per operation.
- Advances the RAM slot address (accum) once per completed division.

Parameters:
UNROLLING, 64, digits per division (enabled cycles per operation)
ONLINE_DELAY, 3, trailing zero-digit flush cycles; input digits accepted = UNROLLING-ONLINE_DELAY
ADDR_WIDTH, 7, width of accum slot address

Ports:
clk  input  1  clock
asyn_reset  input  1  asynchronous reset, active-high
start  input  1  one-cycle request to begin a division; honoured only in IDLE
in_valid  input  1  x_digit/y_digit valid
in_ready  output  1  sequencer accepts digits this cycle
x_digit  input  2  x signed digit {plus,minus}: 10=+1, 01=-1, 00=0
y_digit  input  2  y signed digit, same encoding
enable  output  1  generator advance strobe
refresh  output  1  first-digit marker for the generator
x_in  output  2  x digit to generator
y_in  output  2  y digit to generator
counter  output  11  index of current digit, 0..UNROLLING-1
shift_cnt  output  11  UNROLLING-1-counter
accum  output  ADDR_WIDTH  RAM slot of current division
busy  output  1  high in LOAD or FLUSH
done  output  1  one-cycle pulse after the last enabled cycle
err  output  1  sticky illegal-digit flag (DIGIT_CHECK_EN only, else tied 0)

Behaviour:
- Reset: asyn_reset is asynchronous, active-high; clock is clk. All outputs are registered. Reset clears every output to 0, state to IDLE, and accum to 0.
- States:
  - IDLE: start -> LOAD. counter=0.
  - LOAD: in_ready=1. Each cycle with in_valid&in_ready registers enable=1, x_in=x_digit, y_in=y_digit and increments counter the cycle after. With in_valid=0, enable=0 and counter/x_in/y_in hold (stall).
  - LOAD -> FLUSH after the (UNROLLING-ONLINE_DELAY)th accepted digit.
  - FLUSH: in_ready=0. enable=1 for exactly ONLINE_DELAY consecutive cycles with x_in=y_in=00.
  - FLUSH -> DONE after the last flush cycle (counter=UNROLLING-1).
  - DONE: done=1 for one cycle, accum<=accum+1 (wraps mod 2^ADDR_WIDTH), counter<=0, -> IDLE.
- Timing and field values:
  - refresh=1 only on the enabled cycle with counter==0; otherwise 0.
  - shift_cnt is updated together with counter, always equal to UNROLLING-1-counter (11-bit unsigned).
  - Outputs lag accepted inputs by exactly 1 clk.
- Boundary conditions:
  - start while busy or in DONE: ignored.
  - start and in_valid in the same IDLE cycle: the digit is not accepted (in_ready=0 in IDLE).
  - Reset mid-operation: immediate return to IDLE, accum=0, no done pulse.
  - in_ready is a registered function of state only, never dependent on in_valid.
  - ONLINE_DELAY=0: FLUSH is skipped; LOAD -> DONE.

Optional Feature:
- Macro: DIGIT_CHECK_EN.
- Defined: digit 11 on an accepted x_digit or y_digit sets err (sticky until asyn_reset or next start), and that digit is forwarded as 00.
- Undefined: digits are forwarded unchanged and err is constant 0.

Test Plan:
- Reset, then start, then 61 back-to-back x=10, y=01 -> 64 enable cycles; refresh only on the first; counter 0..63; shift_cnt 63..0; last 3 cycles x_in=y_in=00; done one cycle later; accum=1.
- in_valid deasserted for 5 cycles at digit 20 -> enable=0 for 5 cycles, counter holds 20, total enabled cycles still 64, done timing shifted by 5.
- start pulsed during LOAD, and again during DONE -> ignored; exactly one done pulse, accum increments once.
- 128 consecutive divisions -> accum wraps from 127 to 0 on the 128th done.
- asyn_reset asserted at counter=30 -> all outputs 0 immediately; a subsequent start begins with refresh=1, counter=0.
- DIGIT_CHECK_EN defined, x_digit=11 at digit 5 -> x_in=00 on that cycle and err=1 held through done; err cleared by next start. Undefined -> x_in=11, err=0.

Source files
------------

// File: rtl/online_div_digit_sequencer.sv
// Digit sequencer feeding the online-divider CA-register generator.
// Define DIGIT_CHECK_EN to flag and zero out illegal 11 digits.
module online_div_digit_sequencer #(
    parameter int UNROLLING    = 64,
    parameter int ONLINE_DELAY = 3,
    parameter int ADDR_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            x_digit,
    input  logic [1:0]            y_digit,
    output logic                  enable,
    output logic                  refresh,
    output logic [1:0]            x_in,
    output logic [1:0]            y_in,
    output logic [10:0]           counter,
    output logic [10:0]           shift_cnt,
    output logic [ADDR_WIDTH-1:0] accum,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [10:0] LAST      = 11'(UNROLLING - 1);
    localparam logic [10:0] LOAD_LAST = 11'(UNROLLING - ONLINE_DELAY - 1);
    localparam logic [ADDR_WIDTH-1:0] ACC_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t                state, state_nxt;
    logic [10:0]           idx, idx_nxt;
    logic                  in_ready_nxt, enable_nxt, refresh_nxt;
    logic [1:0]            x_nxt, y_nxt, x_fwd, y_fwd;
    logic [10:0]           counter_nxt, shift_nxt;
    logic [ADDR_WIDTH-1:0] accum_nxt;
    logic                  busy_nxt, done_nxt, err_nxt, bad_dig;

`ifdef DIGIT_CHECK_EN
    assign x_fwd   = (&x_digit) ? 2'b00 : x_digit;
    assign y_fwd   = (&y_digit) ? 2'b00 : y_digit;
    assign bad_dig = (&x_digit) | (&y_digit);
`else
    assign x_fwd   = x_digit;
    assign y_fwd   = y_digit;
    assign bad_dig = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        enable_nxt  = 1'b0;
        refresh_nxt = 1'b0;
        x_nxt       = x_in;
        y_nxt       = y_in;
        counter_nxt = counter;
        shift_nxt   = shift_cnt;
        accum_nxt   = accum;
        done_nxt    = 1'b0;
        err_nxt     = err;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    idx_nxt   = 11'd0;
                    err_nxt   = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    enable_nxt  = 1'b1;
                    refresh_nxt = (idx == 11'd0);
                    x_nxt       = x_fwd;
                    y_nxt       = y_fwd;
                    counter_nxt = idx;
                    shift_nxt   = LAST - idx;
                    idx_nxt     = idx + 11'd1;
                    err_nxt     = err | bad_dig;
                    if (idx == LOAD_LAST)
                        state_nxt = (ONLINE_DELAY == 0) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                enable_nxt  = 1'b1;
                x_nxt       = 2'b00;
                y_nxt       = 2'b00;
                counter_nxt = idx;
                shift_nxt   = LAST - idx;
                idx_nxt     = idx + 11'd1;
                if (idx == LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                done_nxt    = 1'b1;
                accum_nxt   = accum + ACC_ONE;
                counter_nxt = 11'd0;
                shift_nxt   = LAST;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // handshake flags track the state being entered, never in_valid
        in_ready_nxt = (state_nxt == LOAD);
        busy_nxt     = (state_nxt == LOAD) || (state_nxt == FLUSH);
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state     <= IDLE;
            idx       <= '0;
            in_ready  <= 1'b0;
            enable    <= 1'b0;
            refresh   <= 1'b0;
            x_in      <= 2'b00;
            y_in      <= 2'b00;
            counter   <= '0;
            shift_cnt <= '0;
            accum     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            in_ready  <= in_ready_nxt;
            enable    <= enable_nxt;
            refresh   <= refresh_nxt;
            x_in      <= x_nxt;
            y_in      <= y_nxt;
            counter   <= counter_nxt;
            shift_cnt <= shift_nxt;
            accum     <= accum_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_online_div_digit_sequencer.sv
// Directed bench for online_div_digit_sequencer (UNROLLING=64, ONLINE_DELAY=3).
module tb_online_div_digit_sequencer;

    logic        clk = 1'b0;
    logic        asyn_reset;
    logic        start, in_valid, in_ready;
    logic [1:0]  x_digit, y_digit, x_in, y_in;
    logic        enable, refresh, busy, done, err;
    logic [10:0] counter, shift_cnt;
    logic [6:0]  accum;

    int          total = 0;
    int          bad   = 0;
    logic [6:0]  exp_acc = '0;

    online_div_digit_sequencer dut (
        .clk(clk), .asyn_reset(asyn_reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_digit(x_digit), .y_digit(y_digit),
        .enable(enable), .refresh(refresh), .x_in(x_in), .y_in(y_in),
        .counter(counter), .shift_cnt(shift_cnt), .accum(accum),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, enable, 0);
        chk({tag, "_rf"}, refresh, 0);
        chk({tag, "_rdy"}, in_ready, 0);
        chk({tag, "_cnt"}, counter, 0);
        chk({tag, "_sh"}, shift_cnt, 0);
        chk({tag, "_acc"}, accum, 0);
        chk({tag, "_x"}, x_in, 0);
        chk({tag, "_y"}, y_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // One full division; optional stall after digit stall_after and
    // an illegal x digit at index bad_at (-1 disables either).
    task automatic do_div(input int stall_after, input int stall_len,
                          input int bad_at);
        int         en_cnt;
        logic       exp_err;
        logic [1:0] ex;
        en_cnt  = 0;
        exp_err = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("st_ready", in_ready, 1);
        chk("st_busy", busy, 1);
        chk("st_err", err, 0);
        chk("st_en", enable, 0);
        for (int d = 0; d < 61; d++) begin
            in_valid = 1'b1;
            x_digit  = (d == bad_at) ? 2'b11 : 2'b10;
            y_digit  = 2'b01;
            start    = (d == 10);
            tick();
            start  = 1'b0;
            en_cnt += int'(enable);
            ex = 2'b10;
            if (d == bad_at) begin
`ifdef DIGIT_CHECK_EN
                ex      = 2'b00;
                exp_err = 1'b1;
`else
                ex      = 2'b11;
`endif
            end
            chk("ld_en", enable, 1);
            chk("ld_cnt", counter, d);
            chk("ld_shift", shift_cnt, 63 - d);
            chk("ld_refresh", refresh, (d == 0));
            chk("ld_x", x_in, ex);
            chk("ld_y", y_in, 2'b01);
            chk("ld_err", err, exp_err);
            chk("ld_busy", busy, 1);
            if (d == stall_after) begin
                in_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    en_cnt += int'(enable);
                    chk("stall_en", enable, 0);
                    chk("stall_cnt", counter, d);
                    chk("stall_ready", in_ready, 1);
                end
            end
        end
        in_valid = 1'b0;
        x_digit  = 2'b00;
        y_digit  = 2'b00;
        chk("ld_ready_off", in_ready, 0);
        for (int f = 61; f < 64; f++) begin
            tick();
            en_cnt += int'(enable);
            chk("fl_en", enable, 1);
            chk("fl_cnt", counter, f);
            chk("fl_shift", shift_cnt, 63 - f);
            chk("fl_refresh", refresh, 0);
            chk("fl_x", x_in, 0);
            chk("fl_y", y_in, 0);
            chk("fl_ready", in_ready, 0);
            chk("fl_done", done, 0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_acc = exp_acc + 7'd1;
        chk("dn_done", done, 1);
        chk("dn_en", enable, 0);
        chk("dn_acc", accum, exp_acc);
        chk("dn_err", err, exp_err);
        chk("dn_cnt", counter, 0);
        chk("dn_busy", busy, 0);
        chk("dn_total_en", en_cnt, 64);
        tick();
        chk("post_done", done, 0);
        chk("post_ready", in_ready, 0);
        chk("post_busy", busy, 0);
        chk("post_acc", accum, exp_acc);
    endtask

    initial begin
        asyn_reset = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        x_digit    = 2'b00;
        y_digit    = 2'b00;
        tick();
        tick();
        chk_zero("rst");
        asyn_reset = 1'b0;

        start    = 1'b1;
        in_valid = 1'b1;
        x_digit  = 2'b10;
        tick();
        start    = 1'b0;
        chk("idle_noacc_en", enable, 0);
        chk("idle_noacc_rdy", in_ready, 1);
        in_valid = 1'b0;
        asyn_reset = 1'b1;
        tick();
        asyn_reset = 1'b0;

        do_div(-1, 0, -1);
        do_div(20, 5, 5);
        for (int n = 0; n < 126; n++)
            do_div(-1, 0, -1);
        chk("wrap_acc", accum, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x_digit  = 2'b10;
        y_digit  = 2'b01;
        for (int d = 0; d < 31; d++)
            tick();
        chk("mid_cnt", counter, 30);
        #2;
        asyn_reset = 1'b1;
        #1;
        chk_zero("midrst");
        tick();
        asyn_reset = 1'b0;
        in_valid   = 1'b0;
        tick();
        chk("after_rst_done", done, 0);
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        tick();
        chk("re_en", enable, 1);
        chk("re_refresh", refresh, 1);
        chk("re_cnt", counter, 0);
        chk("re_shift", shift_cnt, 63);
        chk("re_acc", accum, 0);
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
